ft_restore_seq: RTL and testbench

Recovery sequencer that sits directly downstream of the fault-tolerance module. On a recovery request it holds both lockstep cores and copies the checkpointed general-purpose registers (x1..x31) and PC from the safe memory into both cores. It then returns the `done` indication that closes the recovery handshake with the fault-tolerance controller. The block is single-clock, fully synchronous and contains no storage for register contents; data streams from the safe-memory read port to the cores' write port.

---
 rtl/ft_restore_seq_if.sv | 34 +++
 rtl/ft_restore_seq.sv | 110 +++++++++++
 tb/tb_ft_restore_seq.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/ft_restore_seq_if.sv
// Bundle of recovery-sequencer signals between the sequencer, safe memory,
// the lockstep cores and the fault-tolerance controller.
interface ft_restore_seq_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  recover_i;
  logic [ADDR_WIDTH-1:0] rf_raddr_o;
  logic [DATA_WIDTH-1:0] rf_rdata_i;
  logic [DATA_WIDTH-1:0] pc_rdata_i;
  logic                  core_halt_o;
  logic                  core_we_o;
  logic [ADDR_WIDTH-1:0] core_waddr_o;
  logic [DATA_WIDTH-1:0] core_wdata_o;
  logic                  core_pc_set_o;
  logic [DATA_WIDTH-1:0] core_pc_o;
  logic                  done_o;
  logic                  busy_o;
  logic [7:0]            restore_cnt_o;

  // Sequencer side
  modport master (
    input  recover_i, rf_rdata_i, pc_rdata_i,
    output rf_raddr_o, core_halt_o, core_we_o, core_waddr_o, core_wdata_o,
           core_pc_set_o, core_pc_o, done_o, busy_o, restore_cnt_o
  );

  // Environment side (controller, safe memory, cores)
  modport slave (
    output recover_i, rf_rdata_i, pc_rdata_i,
    input  rf_raddr_o, core_halt_o, core_we_o, core_waddr_o, core_wdata_o,
           core_pc_set_o, core_pc_o, done_o, busy_o, restore_cnt_o
  );
endinterface

// File: rtl/ft_restore_seq.sv
// Recovery sequencer: halts both lockstep cores, streams checkpointed x1..xN
// from safe memory into the cores, loads the PC, then pulses done.
module ft_restore_seq #(
  parameter int ADDR_WIDTH    = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int SETTLE_CYCLES = 4
) (
  input logic              clk_i,
  input logic              rst_i,
  ft_restore_seq_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_COPY,
    S_PC,
    S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = '1;
  localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR  = ADDR_WIDTH'(1);
  localparam logic [7:0]            SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t                state_q, state_d;
  logic                  recover_q;
  logic [7:0]            settle_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [7:0]            cnt_q;
  logic                  start;

  assign start = bus.recover_i & ~recover_q;

  // State register, settle/address counters, one-stage write pipeline, restore counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      recover_q <= 1'b0;
      settle_q  <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      recover_q <= bus.recover_i;
      case (state_q)
        S_IDLE: if (start) settle_q <= SETTLE_LOAD;
        S_HALT: begin
          if (settle_q != '0) settle_q <= settle_q - 8'd1;
          addr_q <= FIRST_ADDR;
        end
        S_COPY: addr_q <= addr_q + FIRST_ADDR;
        default: ;
      endcase
      // The write lags the read by one cycle to meet the memory read latency
      we_q    <= (state_q == S_COPY);
      waddr_q <= (state_q == S_COPY) ? addr_q : '0;
      if (state_q == S_DONE && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
    end
  end

  // Next-state logic and output decode
  always_comb begin
    state_d           = state_q;
    bus.rf_raddr_o    = '0;
    bus.core_halt_o   = 1'b0;
    bus.core_pc_set_o = 1'b0;
    bus.core_pc_o     = '0;
    bus.done_o        = 1'b0;
    bus.busy_o        = 1'b0;
    bus.core_we_o     = we_q;
    bus.core_waddr_o  = waddr_q;
    bus.core_wdata_o  = we_q ? bus.rf_rdata_i : '0;
    bus.restore_cnt_o = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_HALT;
      end
      S_HALT: begin
        bus.core_halt_o = 1'b1;
        bus.busy_o      = 1'b1;
        if (settle_q == '0) state_d = S_COPY;
      end
      S_COPY: begin
        bus.core_halt_o = 1'b1;
        bus.busy_o      = 1'b1;
        bus.rf_raddr_o  = addr_q;
        if (addr_q == LAST_ADDR) state_d = S_PC;
      end
      S_PC: begin
        bus.core_halt_o   = 1'b1;
        bus.busy_o        = 1'b1;
        bus.core_pc_set_o = 1'b1;
        bus.core_pc_o     = bus.pc_rdata_i;
        state_d           = S_DONE;
      end
      S_DONE: begin
        bus.core_halt_o = 1'b1;
        bus.busy_o      = 1'b1;
        bus.done_o      = 1'b1;
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ft_restore_seq.sv
// Bench for ft_restore_seq: two instances (settle 4 and settle 1) sharing clock/reset.
module tb_ft_restore_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ft_restore_seq_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) if4 ();
  ft_restore_seq_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) if1 ();

  ft_restore_seq #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .SETTLE_CYCLES(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .bus(if4.master));
  ft_restore_seq #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .SETTLE_CYCLES(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .bus(if1.master));

  // Safe memory: one-cycle read latency, content = 0x1000_0000 + address
  assign if4.pc_rdata_i = 32'h0000_0180;
  assign if1.pc_rdata_i = 32'h0000_0180;
  always @(posedge clk) begin
    if4.rf_rdata_i <= 32'h1000_0000 + {27'd0, if4.rf_raddr_o};
    if1.rf_rdata_i <= 32'h1000_0000 + {27'd0, if1.rf_raddr_o};
  end

  typedef struct {
    logic        halt, busy, we, pc_set, done;
    logic [4:0]  raddr, waddr;
    logic [31:0] wdata, pc;
    logic [7:0]  cnt;
  } snap_t;

  typedef struct {
    int    sel;
    int    k;
    snap_t e;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  function automatic vec_t mkv(int sel, int k, logic halt, logic busy, logic [4:0] raddr,
                               logic we, logic [4:0] waddr, logic [31:0] wdata,
                               logic pc_set, logic [31:0] pc, logic done, logic [7:0] cnt);
    vec_t v;
    v.sel = sel; v.k = k;
    v.e.halt = halt; v.e.busy = busy; v.e.raddr = raddr; v.e.we = we;
    v.e.waddr = waddr; v.e.wdata = wdata; v.e.pc_set = pc_set; v.e.pc = pc;
    v.e.done = done; v.e.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s k=%0d actual=%h expected=%h", nm, k, act, exp);
    end
  endtask

  task automatic sample(input int sel, output snap_t s);
    if (sel == 0) begin
      s.halt = if4.core_halt_o; s.busy = if4.busy_o; s.we = if4.core_we_o;
      s.pc_set = if4.core_pc_set_o; s.done = if4.done_o; s.raddr = if4.rf_raddr_o;
      s.waddr = if4.core_waddr_o; s.wdata = if4.core_wdata_o; s.pc = if4.core_pc_o;
      s.cnt = if4.restore_cnt_o;
    end else begin
      s.halt = if1.core_halt_o; s.busy = if1.busy_o; s.we = if1.core_we_o;
      s.pc_set = if1.core_pc_set_o; s.done = if1.done_o; s.raddr = if1.rf_raddr_o;
      s.waddr = if1.core_waddr_o; s.wdata = if1.core_wdata_o; s.pc = if1.core_pc_o;
      s.cnt = if1.restore_cnt_o;
    end
  endtask

  task automatic cmp_snap(input string nm, input int k, input snap_t a, input snap_t e);
    chk({nm, ".halt"},   k, 32'(a.halt),   32'(e.halt));
    chk({nm, ".busy"},   k, 32'(a.busy),   32'(e.busy));
    chk({nm, ".raddr"},  k, 32'(a.raddr),  32'(e.raddr));
    chk({nm, ".we"},     k, 32'(a.we),     32'(e.we));
    chk({nm, ".waddr"},  k, 32'(a.waddr),  32'(e.waddr));
    chk({nm, ".wdata"},  k, a.wdata,       e.wdata);
    chk({nm, ".pc_set"}, k, 32'(a.pc_set), 32'(e.pc_set));
    chk({nm, ".pc"},     k, a.pc,          e.pc);
    chk({nm, ".done"},   k, 32'(a.done),   32'(e.done));
    chk({nm, ".cnt"},    k, 32'(a.cnt),    32'(e.cnt));
  endtask

  task automatic set_rec(input int sel, input logic v);
    if (sel == 0) if4.recover_i = v;
    else          if1.recover_i = v;
  endtask

  // Pulse recover for one cycle and check the whole sequence against the table
  task automatic run_and_check(input int sel, input int s_cyc, input string nm);
    snap_t a;
    int nwe = 0, ndone = 0, bad0 = 0, badseq = 0;
    int exp_wa = 1;
    @(negedge clk);
    set_rec(sel, 1'b1);
    for (int k = 1; k <= s_cyc + 34; k++) begin
      @(negedge clk);
      if (k == 1) set_rec(sel, 1'b0);
      sample(sel, a);
      if (a.we) begin
        nwe++;
        if (a.waddr == 5'd0) bad0++;
        if (32'(a.waddr) != exp_wa) badseq++;
        exp_wa++;
      end
      if (a.done) ndone++;
      foreach (tbl[i])
        if (tbl[i].sel == sel && tbl[i].k == k) cmp_snap(nm, k, a, tbl[i].e);
    end
    chk({nm, ".write_count"}, 0, 32'(nwe), 32'd31);
    chk({nm, ".x0_written"}, 0, 32'(bad0), 32'd0);
    chk({nm, ".waddr_order"}, 0, 32'(badseq), 32'd0);
    chk({nm, ".done_count"}, 0, 32'(ndone), 32'd1);
  endtask

  initial begin
    snap_t a, z;
    int ndone, bad;
    logic [7:0] cnt0;

    z = '{default: '0};
    // S=4 instance (sel 0)
    tbl.push_back(mkv(0, 1,  1, 1, 0,  0, 0,  32'h0,         0, 32'h0,   0, 0));
    tbl.push_back(mkv(0, 4,  1, 1, 0,  0, 0,  32'h0,         0, 32'h0,   0, 0));
    tbl.push_back(mkv(0, 5,  1, 1, 1,  0, 0,  32'h0,         0, 32'h0,   0, 0));
    tbl.push_back(mkv(0, 6,  1, 1, 2,  1, 1,  32'h1000_0001, 0, 32'h0,   0, 0));
    tbl.push_back(mkv(0, 20, 1, 1, 16, 1, 15, 32'h1000_000F, 0, 32'h0,   0, 0));
    tbl.push_back(mkv(0, 35, 1, 1, 31, 1, 30, 32'h1000_001E, 0, 32'h0,   0, 0));
    tbl.push_back(mkv(0, 36, 1, 1, 0,  1, 31, 32'h1000_001F, 1, 32'h180, 0, 0));
    tbl.push_back(mkv(0, 37, 1, 1, 0,  0, 0,  32'h0,         0, 32'h0,   1, 0));
    tbl.push_back(mkv(0, 38, 0, 0, 0,  0, 0,  32'h0,         0, 32'h0,   0, 1));
    // S=1 instance (sel 1)
    tbl.push_back(mkv(1, 1,  1, 1, 0,  0, 0,  32'h0,         0, 32'h0,   0, 0));
    tbl.push_back(mkv(1, 2,  1, 1, 1,  0, 0,  32'h0,         0, 32'h0,   0, 0));
    tbl.push_back(mkv(1, 3,  1, 1, 2,  1, 1,  32'h1000_0001, 0, 32'h0,   0, 0));
    tbl.push_back(mkv(1, 32, 1, 1, 31, 1, 30, 32'h1000_001E, 0, 32'h0,   0, 0));
    tbl.push_back(mkv(1, 33, 1, 1, 0,  1, 31, 32'h1000_001F, 1, 32'h180, 0, 0));
    tbl.push_back(mkv(1, 34, 1, 1, 0,  0, 0,  32'h0,         0, 32'h0,   1, 0));
    tbl.push_back(mkv(1, 35, 0, 0, 0,  0, 0,  32'h0,         0, 32'h0,   0, 1));

    if4.recover_i = 1'b0;
    if1.recover_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    sample(0, a); cmp_snap("reset4", 0, a, z);
    sample(1, a); cmp_snap("reset1", 0, a, z);

    run_and_check(0, 4, "basic");
    run_and_check(1, 1, "min_settle");

    // Held level: one restore only
    ndone = 0;
    cnt0 = if4.restore_cnt_o;
    @(negedge clk);
    if4.recover_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (if4.done_o) ndone++;
    end
    if4.recover_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (if4.done_o) ndone++;
    end
    chk("held.done_count", 0, 32'(ndone), 32'd1);
    chk("held.cnt", 0, 32'(if4.restore_cnt_o), 32'(cnt0) + 32'd1);

    // Edges during COPY are dropped
    ndone = 0;
    cnt0 = if4.restore_cnt_o;
    @(negedge clk);
    if4.recover_i = 1'b1;
    for (int k = 1; k <= 38; k++) begin
      @(negedge clk);
      if (if4.done_o) ndone++;
      if (k == 1 || k == 11 || k == 13) if4.recover_i = 1'b0;
      if (k == 10 || k == 12) if4.recover_i = 1'b1;
    end
    chk("busy_edge.busy_end", 38, 32'(if4.busy_o), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (if4.done_o) ndone++;
    end
    chk("busy_edge.done_count", 0, 32'(ndone), 32'd1);
    chk("busy_edge.cnt", 0, 32'(if4.restore_cnt_o), 32'(cnt0) + 32'd1);

    // Reset in the middle of COPY
    @(negedge clk);
    if4.recover_i = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) if4.recover_i = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    sample(0, a); cmp_snap("midreset", 21, a, z);
    rst = 1'b0;
    bad = 0;
    for (int k = 22; k <= 60; k++) begin
      @(negedge clk);
      if (if4.done_o || if4.core_we_o || if4.core_halt_o || if4.restore_cnt_o != 8'd0) bad++;
    end
    chk("midreset.quiet", 60, 32'(bad), 32'd0);
    run_and_check(0, 4, "after_reset");

    // Saturation on the S=1 instance (counter is 0 after the reset above)
    for (int i = 1; i <= 256; i++) begin
      @(negedge clk);
      if1.recover_i = 1'b1;
      for (int k = 1; k <= 35; k++) begin
        @(negedge clk);
        if (k == 1) if1.recover_i = 1'b0;
      end
      chk("sat.cnt", i, 32'(if1.restore_cnt_o), (i > 255) ? 32'd255 : 32'(i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
